mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares one single-port unified memory between instruction fetch (I) and the data/memory stage (D).
//  Sits between fetch/memory stages and the memory macro for the pipelined/multi-cycle core.
//  Serialises accesses, owns the memory-side request handshake, flags misaligned and timed-out accesses.
// PARAMETERS
//  ADDR_W        16  address width (byte addresses, word-aligned accesses)
//  DATA_W        16  data word width
//  TIMEOUT       64  max cycles in a busy state without mem_ready before abort (>=2)
//  STARVE_LIMIT   4  consecutive D grants with I pending before I is forced (ARB_FAIRNESS_EN only)
// PORTS
//  clk        in   1       system clock, all state on rising edge
//  rst        in   1       synchronous reset, ACTIVE-LOW (0 = reset)
//  i_req      in   1       fetch request; held with i_addr stable until i_ack
//  i_addr     in   ADDR_W  fetch address
//  i_ack      out  1       one-cycle completion pulse to fetch
//  i_rdata    out  DATA_W  fetch read data, valid while i_ack=1
//  d_req      in   1       data request; held with d_we/d_addr/d_wdata stable until d_ack
//  d_we       in   1       1 = write, 0 = read
//  d_addr     in   ADDR_W  data address
//  d_wdata    in   DATA_W  data write word
//  d_ack      out  1       one-cycle completion pulse to data stage
//  d_rdata    out  DATA_W  data read word, valid while d_ack=1 and d_we=0
//  mem_req    out  1       memory request, high for the whole access
//  mem_we     out  1       memory write enable (registered)
//  mem_addr   out  ADDR_W  memory address (registered)
//  mem_wdata  out  DATA_W  memory write data (registered)
//  mem_rdata  in   DATA_W  memory read data, valid with mem_ready
//  mem_ready  in   1       memory completion, may arrive any cycle mem_req=1
//  busy       out  1       access in flight (state != IDLE)
//  err        out  1       one-cycle pulse with the ack of a faulted access
// BEHAVIOUR
//  Reset (rst=0 at edge): state IDLE, all outputs 0, timeout/starve counters 0. Mid-access reset
//   abandons the access; mem_req falls next cycle, no ack issued.
//  States: IDLE, BUSY_I, BUSY_D.
//  IDLE: priority d_req over i_req. Grant latches addr/we/wdata into mem_* regs, goes BUSY_x.
//   No request -> stay IDLE, mem_* regs hold.
//  Misaligned D (d_addr[0]=1) in IDLE: no memory access; d_ack=1 and err=1 combinationally
//   that cycle, stay IDLE. Misaligned I: same on i_ack (only when no D request is pending).
//  BUSY_x: mem_req=1. mem_ready=1 -> x_ack=1 and x_rdata=mem_rdata combinationally that cycle,
//   next state IDLE. Minimum access = 2 cycles (grant cycle + ready cycle).
//  Timeout counter clears on grant, increments each BUSY cycle without mem_ready; reaching
//   TIMEOUT-1 -> x_ack=1, err=1, x_rdata=0, next state IDLE.
//  mem_ready outside BUSY is ignored. mem_ready and timeout in same cycle -> normal completion, err=0.
//  Requester drops req in cycle after ack; IDLE then re-arbitrates (back-to-back D then I allowed).
//  Req dropped before ack is a requester protocol violation; the access still completes; ack is ignored.
//  Outputs i_ack, d_ack, err are never high together except x_ack with err.
// CONFIGURATION
//  ARB_FAIRNESS_EN defined: starve counter increments on each D grant while i_req=1, clears on
//   any I grant. At STARVE_LIMIT, next IDLE arbitration grants I even if d_req=1.
//  ARB_FAIRNESS_EN undefined: strict D priority, no starve counter logic.
// STRUCTURE
//  Package mem_arb_pkg: state encoding (IDLE=2'b00, BUSY_I=2'b01, BUSY_D=2'b10), ACK_* localparams,
//   TIMEOUT counter width function ($clog2).
//  One sub-module mem_arb_timer: loadable saturating down-counter with clear, load, and expire output.
//   Instanced once for the timeout.
//  Arbitration, FSM and mem_* regs stay in mem_arbiter.
// TESTING
//  Reset: hold rst=0 with i_req=d_req=1 for 3 cycles -> all outputs 0, busy=0.
//  Simultaneous i_req (0x0010) and d_req read (0x0200), mem_ready 1 cycle after mem_req:
//   D served first (d_ack cycle 2), I served next (i_ack cycle 4), mem_addr 0x0200 then 0x0010.
//  D write 0x0A04 <- 0xBEEF, mem_ready after 5 cycles: mem_we=1, mem_wdata=0xBEEF held
//   constant 5 cycles, one d_ack pulse, err=0.
//  d_addr=0x0003: d_ack=1, err=1 same cycle, mem_req stays 0.
//  No mem_ready with TIMEOUT=8: d_ack=1, err=1, d_rdata=0 after 8 busy cycles, busy=0 next cycle.
//  ARB_FAIRNESS_EN, STARVE_LIMIT=4: continuous d_req and i_req -> grant pattern D,D,D,D,I repeating;
//   without the macro, I never granted.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified-memory arbiter.
//   arb_state_t  : FSM state encoding (IDLE / BUSY_I / BUSY_D)
//   ACK_*        : selects which requester receives the completion pulse
//   timer_width  : counter width that holds TIMEOUT-1
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY_I = 2'b01,
    BUSY_D = 2'b10
  } arb_state_t;

  localparam logic [1:0] ACK_NONE = 2'b00;
  localparam logic [1:0] ACK_I    = 2'b01;
  localparam logic [1:0] ACK_D    = 2'b10;

  function automatic int timer_width(input int timeout);
    return (timeout < 2) ? 1 : $clog2(timeout);
  endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// Loadable saturating down-counter used as the access timeout.
//   clk      in  system clock
//   rst      in  synchronous reset, active low
//   clr      in  force count to zero
//   load     in  load load_val (lower priority than clr)
//   load_val in  value loaded on load
//   dec      in  decrement by one, saturating at zero
//   expire   out count is zero
module mem_arb_timer #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         expire
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expire = (cnt == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch (I)
// and the data stage (D). Serialises accesses, drives the memory request,
// flags misaligned and timed-out accesses.
//
// Optional feature: define ARB_FAIRNESS_EN to force an I grant after
// STARVE_LIMIT consecutive D grants taken while I was waiting. Without it
// D has strict priority.
//
// Ports
//   clk, rst                 clock, synchronous active-low reset
//   i_req/i_addr             fetch request and address
//   i_ack/i_rdata            fetch completion pulse and read data
//   d_req/d_we/d_addr/d_wdata data request, write flag, address, write word
//   d_ack/d_rdata            data completion pulse and read data
//   mem_req/mem_we/mem_addr/mem_wdata  memory-side request (addr/we/wdata registered)
//   mem_rdata/mem_ready      memory read data and completion
//   busy                     access in flight
//   err                      pulses with the ack of a faulted access
//
// state  | meaning
// IDLE   | no access in flight; arbitrate, ack misaligned requests directly
// BUSY_I | fetch access on the memory bus, waiting for mem_ready or timeout
// BUSY_D | data access on the memory bus, waiting for mem_ready or timeout
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int TIMEOUT      = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              err
);

  localparam int TMR_W = timer_width(TIMEOUT);

  arb_state_t        state, state_nxt;
  logic [1:0]        ack_sel;
  logic [DATA_W-1:0] ack_rdata;
  logic              grant_i, grant_d;
  logic              tmr_dec, tmr_clr, tmr_expire;
  logic              force_i;
  logic              pick_d, pick_i;

  mem_arb_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (tmr_clr),
    .load     (grant_i | grant_d),
    .load_val (TMR_W'(TIMEOUT - 1)),
    .dec      (tmr_dec),
    .expire   (tmr_expire)
  );

`ifdef ARB_FAIRNESS_EN
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  logic [STARVE_W-1:0] starve_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (grant_i) begin
      starve_cnt <= '0;
    end else if (grant_d && i_req && (starve_cnt != STARVE_MAX)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  assign force_i = (starve_cnt == STARVE_MAX);
`else
  assign force_i = 1'b0;
`endif

  // Forcing I only matters while I is actually asking.
  assign pick_d = d_req && !(force_i && i_req);
  assign pick_i = i_req && !pick_d;

  always_comb begin
    state_nxt = state;
    ack_sel   = ACK_NONE;
    ack_rdata = '0;
    err       = 1'b0;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    tmr_dec   = 1'b0;
    // Acks are suppressed while reset is asserted so an abandoned access never completes.
    if (rst) begin
      case (state)
        IDLE: begin
          if (pick_d) begin
            if (d_addr[0]) begin
              ack_sel = ACK_D;
              err     = 1'b1;
            end else begin
              grant_d   = 1'b1;
              state_nxt = BUSY_D;
            end
          end else if (pick_i) begin
            if (i_addr[0]) begin
              ack_sel = ACK_I;
              err     = 1'b1;
            end else begin
              grant_i   = 1'b1;
              state_nxt = BUSY_I;
            end
          end
        end
        BUSY_I, BUSY_D: begin
          if (mem_ready) begin
            ack_sel   = (state == BUSY_I) ? ACK_I : ACK_D;
            ack_rdata = mem_rdata;
            state_nxt = IDLE;
          end else if (tmr_expire) begin
            ack_sel   = (state == BUSY_I) ? ACK_I : ACK_D;
            err       = 1'b1;
            state_nxt = IDLE;
          end else begin
            tmr_dec = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign tmr_clr = (state != IDLE) && (state_nxt == IDLE);

  assign i_ack   = (ack_sel == ACK_I);
  assign d_ack   = (ack_sel == ACK_D);
  assign i_rdata = i_ack ? ack_rdata : '0;
  assign d_rdata = d_ack ? ack_rdata : '0;
  assign mem_req = (state != IDLE);
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state <= state_nxt;
      if (grant_d) begin
        mem_we    <= d_we;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
      end else if (grant_i) begin
        mem_we   <= 1'b0;
        mem_addr <= i_addr;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [15:0] i_addr;
  logic        i_ack;
  logic [15:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_ack;
  logic [15:0] d_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  logic        busy;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;
  int acks;
  logic exp_i;

  mem_arbiter #(
    .ADDR_W       (16),
    .DATA_W       (16),
    .TIMEOUT      (8),
    .STARVE_LIMIT (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_ack     (i_ack),
    .i_rdata   (i_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ack     (d_ack),
    .d_rdata   (d_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .busy      (busy),
    .err       (err)
  );

  // Memory model: read data is the address scrambled with a fixed pattern.
  assign mem_rdata = mem_addr ^ 16'h5A5A;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; i_req = 1'b1; d_req = 1'b1; i_addr = 16'h0010; d_addr = 16'h0200;
    d_we = 1'b0; d_wdata = 16'h1234; mem_ready = 1'b0;

    // Reset held with both requests pending
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      chk("rst_ctl", {i_ack, d_ack, err, mem_req, mem_we, busy}, 64'd0);
      chk("rst_bus", {mem_addr, mem_wdata, i_rdata, d_rdata}, 64'd0);
    end
    @(negedge clk); rst = 1'b1; i_req = 1'b0; d_req = 1'b0; #1;
    chk("post_rst_idle", {busy, i_ack, d_ack}, 64'd0);

    // Simultaneous I and D: D first, then I
    @(negedge clk); i_req = 1'b1; i_addr = 16'h0010; d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0200; #1;
    chk("sim_c1", {i_ack, d_ack, busy}, 64'd0);
    @(negedge clk); mem_ready = 1'b1; #1;
    chk("sim_c2_addr", mem_addr, 64'h0200);
    chk("sim_c2_ack", {mem_req, d_ack, i_ack, err}, 64'b1100);
    chk("sim_c2_rdata", d_rdata, 64'(16'h0200 ^ 16'h5A5A));
    @(negedge clk); d_req = 1'b0; mem_ready = 1'b0; #1;
    chk("sim_c3", {busy, i_ack, d_ack}, 64'd0);
    @(negedge clk); mem_ready = 1'b1; #1;
    chk("sim_c4_addr", mem_addr, 64'h0010);
    chk("sim_c4_ack", {mem_req, mem_we, d_ack, i_ack, err}, 64'b10010);
    chk("sim_c4_rdata", i_rdata, 64'(16'h0010 ^ 16'h5A5A));
    @(negedge clk); i_req = 1'b0; mem_ready = 1'b0; #1;
    chk("sim_c5", busy, 64'd0);

    // D write, ready on the fifth busy cycle
    @(negedge clk); d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0A04; d_wdata = 16'hBEEF; #1;
    chk("wr_grant", {busy, d_ack}, 64'd0);
    acks = 0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk); mem_ready = (k == 5); #1;
      chk("wr_bus", {mem_req, mem_we, mem_addr, mem_wdata}, {30'd0, 1'b1, 1'b1, 16'h0A04, 16'hBEEF});
      chk("wr_ack", {d_ack, err}, {62'd0, (k == 5), 1'b0});
      if (d_ack) acks++;
    end
    @(negedge clk); d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b0; #1;
    chk("wr_pulses", acks, 64'd1);
    chk("wr_idle", busy, 64'd0);

    // Misaligned D and I
    @(negedge clk); d_req = 1'b1; d_addr = 16'h0003; #1;
    chk("misd_ack", {d_ack, err, i_ack, mem_req, busy}, 64'b11000);
    @(negedge clk); d_req = 1'b0; #1;
    chk("misd_after", {mem_req, busy, d_ack, err}, 64'd0);
    @(negedge clk); i_req = 1'b1; i_addr = 16'h0011; #1;
    chk("misi_ack", {i_ack, err, d_ack, mem_req}, 64'b1100);
    @(negedge clk); i_req = 1'b0; #1;
    chk("misi_after", {mem_req, busy, i_ack, err}, 64'd0);

    // mem_ready while idle is ignored
    @(negedge clk); mem_ready = 1'b1; #1;
    chk("rdy_idle", {i_ack, d_ack, err, busy}, 64'd0);
    @(negedge clk); mem_ready = 1'b0; #1;
    chk("rdy_idle2", {busy, mem_req}, 64'd0);

    // Timeout: no mem_ready for 8 busy cycles
    @(negedge clk); d_req = 1'b1; d_addr = 16'h0100; #1;
    chk("to_grant", busy, 64'd0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk); #1;
      chk("to_busy", busy, 64'd1);
      chk("to_ack", {d_ack, err, i_ack}, {61'd0, (k == 8), (k == 8), 1'b0});
      if (k == 8) chk("to_rdata", d_rdata, 64'd0);
    end
    @(negedge clk); d_req = 1'b0; #1;
    chk("to_idle", {busy, mem_req}, 64'd0);

    // mem_ready on the timeout cycle wins: normal completion
    @(negedge clk); d_req = 1'b1; d_addr = 16'h0104; #1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk); mem_ready = (k == 8); #1;
      chk("tor_ack", {d_ack, err}, {62'd0, (k == 8), 1'b0});
      if (k == 8) chk("tor_rdata", d_rdata, 64'(16'h0104 ^ 16'h5A5A));
    end
    @(negedge clk); d_req = 1'b0; mem_ready = 1'b0; #1;
    chk("tor_idle", busy, 64'd0);

    // Reset in the middle of an access: no ack, mem_req drops
    @(negedge clk); d_req = 1'b1; d_addr = 16'h0108; #1;
    @(negedge clk); #1;
    chk("mrst_busy", {busy, mem_req}, 64'b11);
    @(negedge clk); rst = 1'b0; mem_ready = 1'b1; #1;
    chk("mrst_noack", {d_ack, i_ack, err}, 64'd0);
    @(negedge clk); rst = 1'b1; d_req = 1'b0; mem_ready = 1'b0; #1;
    chk("mrst_idle", {mem_req, busy}, 64'd0);

    // Continuous I and D requests, memory always ready
    @(negedge clk); i_req = 1'b1; i_addr = 16'h0020; d_req = 1'b1; d_we = 1'b0;
    d_addr = 16'h0300; mem_ready = 1'b1; #1;
    for (int g = 0; g < 10; g++) begin
      chk("fair_idle", {i_ack, d_ack, busy}, 64'd0);
      @(negedge clk); #1;
`ifdef ARB_FAIRNESS_EN
      exp_i = ((g % 5) == 4);
`else
      exp_i = 1'b0;
`endif
      chk("fair_grant", {i_ack, d_ack}, {62'd0, exp_i, ~exp_i});
      @(negedge clk); #1;
    end
    i_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
    @(negedge clk); #1;
    chk("end_idle", busy, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
